// File: rtl/comparator_monitor.sv
// -----------------------------------------------------------------------------
// comparator_monitor
//
// Purpose:
//    Conditions CHANNELS raw asynchronous comparator outputs. Each channel is
//    synchronised (2 flops), debounced against a shared threshold, and its
//    debounced rising transitions are counted by a saturating event counter
//    with a sticky overflow flag. One channel's counter and overflow flag are
//    read out through a select mux.
//
// Configuration macro:
//    COMPARATOR_MONITOR_TRIP_EN - when defined, trip[i] latches on the first
//    debounced rising transition of channel i and holds until reset. When
//    undefined, trip is tied to 0 and no trip registers exist.
//
// Ports:
//    clk      - clock, all state on its rising edge
//    rst_n    - asynchronous active-low reset
//    ena      - clock enable; low freezes every register
//    cmp_in   - raw comparator inputs, one per channel (asynchronous)
//    thresh   - debounce threshold shared by all channels (0 acts as 1)
//    sel      - readout channel select (out-of-range values read channel 0)
//    clr      - synchronous clear of event counters and overflow flags
//    cmp_out  - debounced comparator levels
//    edge_cnt - event count of the selected channel
//    ovf      - sticky overflow flag of the selected channel
//    trip     - latched first-trip flags
// -----------------------------------------------------------------------------
module comparator_monitor #(
   parameter int CHANNELS = 4,
   parameter int DEB_W    = 4,
   parameter int CNT_W    = 8,
   localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic [CHANNELS-1:0] cmp_in,
   input  logic [DEB_W-1:0]    thresh,
   input  logic [SEL_W-1:0]    sel,
   input  logic                clr,
   output logic [CHANNELS-1:0] cmp_out,
   output logic [CNT_W-1:0]    edge_cnt,
   output logic                ovf,
   output logic [CHANNELS-1:0] trip
);

   logic [CHANNELS-1:0]             sync1_q, sync1_d;
   logic [CHANNELS-1:0]             sync2_q, sync2_d;
   logic [CHANNELS-1:0]             cmp_out_q, cmp_out_d;
   logic [CHANNELS-1:0][DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
   logic [CHANNELS-1:0][CNT_W-1:0]  evt_cnt_q, evt_cnt_d;
   logic [CHANNELS-1:0]             ovf_q, ovf_d;
   logic [CHANNELS-1:0]             rise;
   logic [DEB_W:0]                  eff_thresh;

   // One extra bit so the incremented count can never wrap before comparing.
   assign eff_thresh = (thresh == '0) ? (DEB_W+1)'(1) : {1'b0, thresh};

   always_comb begin
      logic [DEB_W:0] inc;
      // NOTE: every combinational output gets a default before any branch,
      // so no path leaves a signal unassigned and no latch is inferred.
      sync1_d   = sync1_q;
      sync2_d   = sync2_q;
      cmp_out_d = cmp_out_q;
      deb_cnt_d = deb_cnt_q;
      evt_cnt_d = evt_cnt_q;
      ovf_d     = ovf_q;
      rise      = '0;
      inc       = '0;
      if (ena) begin
         sync1_d = cmp_in;
         sync2_d = sync1_q;
         for (int i = 0; i < CHANNELS; i++) begin
            if (sync2_q[i] != cmp_out_q[i]) begin
               inc = {1'b0, deb_cnt_q[i]} + (DEB_W+1)'(1);
               // >= rather than == so a threshold lowered below the running
               // count toggles on the next qualifying edge.
               if (inc >= eff_thresh) begin
                  cmp_out_d[i] = ~cmp_out_q[i];
                  deb_cnt_d[i] = '0;
               end else begin
                  deb_cnt_d[i] = inc[DEB_W-1:0];
               end
            end else begin
               // Input agrees with the output: any partial count was a glitch.
               deb_cnt_d[i] = '0;
            end
         end
         rise = cmp_out_d & ~cmp_out_q;
         for (int i = 0; i < CHANNELS; i++) begin
            if (clr) begin
               // Clear dominates a coincident rising transition.
               evt_cnt_d[i] = '0;
               ovf_d[i]     = 1'b0;
            end else if (rise[i]) begin
               if (evt_cnt_q[i] == {CNT_W{1'b1}}) begin
                  ovf_d[i] = 1'b1;
               end else begin
                  evt_cnt_d[i] = evt_cnt_q[i] + CNT_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         cmp_out_q <= '0;
         deb_cnt_q <= '0;
         evt_cnt_q <= '0;
         ovf_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge
         // values; this is what makes sync1 -> sync2 a real two-stage chain.
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         cmp_out_q <= cmp_out_d;
         deb_cnt_q <= deb_cnt_d;
         evt_cnt_q <= evt_cnt_d;
         ovf_q     <= ovf_d;
      end
   end

`ifdef COMPARATOR_MONITOR_TRIP_EN
   logic [CHANNELS-1:0] trip_q, trip_d;

   // rise is already zero while ena is low, so this holds when frozen.
   always_comb begin
      trip_d = trip_q | rise;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trip_q <= '0;
      end else begin
         trip_q <= trip_d;
      end
   end

   assign trip = trip_q;
`else
   assign trip = '0;
`endif

   // Readout mux: channel 0 is the default, so out-of-range selects fall to it.
   always_comb begin
      edge_cnt = evt_cnt_q[0];
      ovf      = ovf_q[0];
      for (int i = 1; i < CHANNELS; i++) begin
         if (int'(sel) == i) begin
            edge_cnt = evt_cnt_q[i];
            ovf      = ovf_q[i];
         end
      end
   end

   assign cmp_out = cmp_out_q;

endmodule

// File: tb/tb_comparator_monitor.sv
// -----------------------------------------------------------------------------
// tb_comparator_monitor
//
// Purpose:
//    Self-checking bench for comparator_monitor (CHANNELS=4, DEB_W=4,
//    CNT_W=8) plus a second CHANNELS=5 instance used for out-of-range select
//    readout. A behavioural model tracks each channel as "input sampled two
//    edges ago" and a mismatch run length, and is compared with the DUT on
//    every falling edge. Directed literal expectations pin key points.
//    Trip expectations follow COMPARATOR_MONITOR_TRIP_EN.
// -----------------------------------------------------------------------------
module tb_comparator_monitor;

   localparam int CH = 4;
`ifdef COMPARATOR_MONITOR_TRIP_EN
   localparam bit TRIP_EN = 1'b1;
`else
   localparam bit TRIP_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ena;
   logic [CH-1:0] cmp_in;
   logic [3:0]    thresh;
   logic [1:0]    sel;
   logic          clr;
   logic [CH-1:0] cmp_out;
   logic [7:0]    edge_cnt;
   logic          ovf;
   logic [CH-1:0] trip;

   logic [4:0]    cmp_in2;
   logic [2:0]    sel2;
   logic [4:0]    cmp_out2;
   logic [7:0]    edge_cnt2;
   logic          ovf2;
   logic [4:0]    trip2;

   int passed = 0;
   int total  = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   comparator_monitor #(.CHANNELS(CH), .DEB_W(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .cmp_in(cmp_in), .thresh(thresh),
      .sel(sel), .clr(clr), .cmp_out(cmp_out), .edge_cnt(edge_cnt),
      .ovf(ovf), .trip(trip)
   );

   comparator_monitor #(.CHANNELS(5), .DEB_W(4), .CNT_W(8)) dut5 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .cmp_in(cmp_in2), .thresh(thresh),
      .sel(sel2), .clr(clr), .cmp_out(cmp_out2), .edge_cnt(edge_cnt2),
      .ovf(ovf2), .trip(trip2)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         passed++;
      end
   endtask

   // ---------------- behavioural model (main instance) ----------------
   bit [CH-1:0] samp1, samp2;   // input as seen one and two enabled edges ago
   int          run   [CH];     // consecutive edges the synchronised input disagreed
   bit          out_m [CH];
   int          cnt_m [CH];
   bit          ovf_m [CH];
   bit          trip_m[CH];

   task automatic model_reset();
      samp1 = '0;
      samp2 = '0;
      for (int c = 0; c < CH; c++) begin
         run[c] = 0; out_m[c] = 0; cnt_m[c] = 0; ovf_m[c] = 0; trip_m[c] = 0;
      end
   endtask

   always @(negedge rst_n) model_reset();

   always @(posedge clk) begin
      if (!rst_n) begin
         model_reset();
      end else if (ena) begin
         int eff;
         eff = (thresh == 0) ? 1 : int'(thresh);
         for (int c = 0; c < CH; c++) begin
            bit prev;
            prev = out_m[c];
            if (samp2[c] != out_m[c]) begin
               run[c]++;
               if (run[c] >= eff) begin
                  out_m[c] = !out_m[c];
                  run[c]   = 0;
               end
            end else begin
               run[c] = 0;
            end
            if (clr) begin
               cnt_m[c] = 0;
               ovf_m[c] = 0;
            end else if (!prev && out_m[c]) begin
               if (cnt_m[c] == 255) ovf_m[c] = 1;
               else                 cnt_m[c]++;
            end
            if (!prev && out_m[c]) trip_m[c] = 1;
         end
         samp2 = samp1;
         samp1 = cmp_in;
      end
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         logic [CH-1:0] exp_out, exp_trip;
         for (int c = 0; c < CH; c++) begin
            exp_out[c]  = out_m[c];
            exp_trip[c] = TRIP_EN & trip_m[c];
         end
         check("cmp_out", 32'(cmp_out), 32'(exp_out));
         check("edge_cnt", 32'(edge_cnt), 32'(cnt_m[sel]));
         check("ovf", 32'(ovf), 32'(ovf_m[sel]));
         check("trip", 32'(trip), 32'(exp_trip));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      ena     = 1'b1;
      cmp_in  = '0;
      cmp_in2 = '0;
      thresh  = 4'd3;
      sel     = 2'd0;
      sel2    = 3'd0;
      clr     = 1'b0;
      chk_en  = 1'b1;
      tick(2);
      check("rst_cmp_out", 32'(cmp_out), 32'h0);
      check("rst_edge_cnt", 32'(edge_cnt), 32'h0);
      check("rst_ovf", 32'(ovf), 32'h0);
      check("rst_trip", 32'(trip), 32'h0);
      rst_n = 1'b1;
      tick(1);

      // Rising input on ch0 with thresh=3: out rises exactly 5 edges later.
      cmp_in = 4'b0001;
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         check($sformatf("lat5_edge%0d", k), 32'(cmp_out[0]), (k < 5) ? 32'h0 : 32'h1);
      end
      check("lat5_cnt0", 32'(edge_cnt), 32'd1);
      check("model_cnt0", 32'(cnt_m[0]), 32'd1);

      // Two-cycle glitch on ch1 is rejected.
      cmp_in = 4'b0011;
      tick(2);
      cmp_in = 4'b0001;
      tick(8);
      sel = 2'd1;
      #1;
      check("glitch_out1", 32'(cmp_out[1]), 32'h0);
      check("glitch_cnt1", 32'(edge_cnt), 32'h0);

      // clr on the same edge ch3 rises: count stays 0, trip still latches.
      sel    = 2'd3;
      cmp_in = 4'b1001;
      tick(4);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("clr_rise_out3", 32'(cmp_out[3]), 32'h1);
      check("clr_rise_cnt3", 32'(edge_cnt), 32'h0);
      check("clr_rise_trip3", 32'(trip[3]), 32'(TRIP_EN));
      check("model_out3", 32'(out_m[3]), 32'h1);

      // 256 debounced pulses on ch2 (thresh=1 keeps them short).
      thresh = 4'd1;
      sel    = 2'd2;
      for (int p = 1; p <= 256; p++) begin
         cmp_in = 4'b1101;
         tick(4);
         cmp_in = 4'b1001;
         tick(4);
         if (p == 255) begin
            check("sat_cnt255", 32'(edge_cnt), 32'd255);
            check("sat_ovf_pre", 32'(ovf), 32'h0);
         end
      end
      check("sat_cnt256", 32'(edge_cnt), 32'd255);
      check("sat_ovf", 32'(ovf), 32'h1);
      check("model_ovf2", 32'(ovf_m[2]), 32'h1);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("clr_cnt2", 32'(edge_cnt), 32'h0);
      check("clr_ovf2", 32'(ovf), 32'h0);
      check("clr_keeps_out", 32'(cmp_out), 32'b1001);

      // ena low for 10 cycles with inputs toggling: everything freezes.
      ena = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cmp_in = ~cmp_in;
         tick(1);
      end
      check("frozen_out", 32'(cmp_out), 32'b1001);
      check("frozen_cnt", 32'(edge_cnt), 32'h0);
      cmp_in = 4'b1001;
      ena    = 1'b1;
      tick(3);
      check("resume_out", 32'(cmp_out), 32'b1001);

      // Reset mid-debounce (ch1 count at 2 of 3), then full requalification.
      thresh = 4'd3;
      sel    = 2'd0;
      cmp_in = 4'b1011;
      tick(4);
      check("middeb_out", 32'(cmp_out), 32'b1001);
      rst_n = 1'b0;
      #2;
      check("rstpulse_out", 32'(cmp_out), 32'h0);
      check("rstpulse_cnt", 32'(edge_cnt), 32'h0);
      check("rstpulse_trip", 32'(trip), 32'h0);
      #1;
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         check($sformatf("requal_edge%0d", k), 32'(cmp_out), (k < 5) ? 32'h0 : 32'b1011);
      end
      check("requal_cnt0", 32'(edge_cnt), 32'd1);

      // thresh=0 behaves as 1: 3-edge latency on the falling ch1.
      thresh = 4'd0;
      cmp_in = 4'b1001;
      for (int k = 1; k <= 3; k++) begin
         tick(1);
         check($sformatf("th0_edge%0d", k), 32'(cmp_out), (k < 3) ? 32'b1011 : 32'b1001);
      end

      // Threshold lowered below a running count toggles on the next edge.
      thresh = 4'd5;
      sel    = 2'd2;
      cmp_in = 4'b1101;
      tick(5);
      check("thdrop_before", 32'(cmp_out[2]), 32'h0);
      thresh = 4'd2;
      tick(1);
      check("thdrop_after", 32'(cmp_out[2]), 32'h1);
      check("thdrop_cnt2", 32'(edge_cnt), 32'd1);

      // Out-of-range select on the 5-channel instance reads channel 0.
      thresh  = 4'd0;
      cmp_in2 = 5'b00001;
      tick(4);
      check("ch5_out", 32'(cmp_out2), 32'b00001);
      sel2 = 3'd5;
      #1;
      check("sel5_cnt", 32'(edge_cnt2), 32'd1);
      sel2 = 3'd7;
      #1;
      check("sel7_cnt", 32'(edge_cnt2), 32'd1);
      sel2 = 3'd1;
      #1;
      check("sel1_cnt", 32'(edge_cnt2), 32'd0);
      check("ch5_ovf", 32'(ovf2), 32'h0);
      check("ch5_trip", 32'(trip2), 32'(TRIP_EN));

      tick(2);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
